// File: rtl/ulpb_pkg.sv
// ulpb_pkg: shared ULPB state encodings and the log2 helper.
`default_nettype none

package ulpb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    REL   = 3'd2,
    WAIT  = 3'd3,
    RACK  = 3'd4,
    FLUSH = 3'd5
  } ulpb_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ulpb_msg_fifo.sv
// ulpb_msg_fifo: {addr, data, last} storage with wrap-bit pointers and write-pointer rewind.
`default_nettype none

module ulpb_msg_fifo
  import ulpb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int PTR_WIDTH  = clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  input  logic                  pop,
  input  logic                  rewind,
  input  logic [PTR_WIDTH-1:0]  rewind_ptr,
  output logic [PTR_WIDTH-1:0]  wr_ptr,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH-1:0] head_addr,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_last
);

  localparam int IDX_WIDTH = PTR_WIDTH - 1;

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic                  last_mem [DEPTH];
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [IDX_WIDTH-1:0]  wr_idx;
  logic [IDX_WIDTH-1:0]  rd_idx;

  assign wr_idx = wr_ptr[IDX_WIDTH-1:0];
  assign rd_idx = rd_ptr[IDX_WIDTH-1:0];

  // Storage is cleared on reset so the node-facing head outputs read zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
        last_mem[i] <= 1'b0;
      end
    end else if (push) begin
      addr_mem[wr_idx] <= push_addr;
      data_mem[wr_idx] <= push_data;
      last_mem[wr_idx] <= push_last;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (rewind)
        wr_ptr <= rewind_ptr;
      else if (push)
        wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_WIDTH'(1);
    end
  end

  assign full      = (wr_ptr ^ rd_ptr) == {1'b1, {IDX_WIDTH{1'b0}}};
  assign empty     = (wr_ptr == rd_ptr);
  assign head_addr = addr_mem[rd_idx];
  assign head_data = data_mem[rd_idx];
  assign head_last = last_mem[rd_idx];

endmodule

`default_nettype wire

// File: rtl/ulpb_tx_queue.sv
// ulpb_tx_queue: buffers complete host messages and drives the node's four-phase TX handshake.
`default_nettype none

module ulpb_tx_queue
  import ulpb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [ADDR_WIDTH-1:0] HOST_ADDR,
  input  logic [DATA_WIDTH-1:0] HOST_DATA,
  input  logic                  HOST_LAST,
  input  logic                  HOST_VALID,
  output logic                  HOST_READY,
  output logic [ADDR_WIDTH-1:0] TX_ADDR,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_PEND,
  output logic                  TX_REQ,
  input  logic                  TX_ACK,
  input  logic                  TX_SUCC,
  input  logic                  TX_FAIL,
  output logic                  TX_RESP_ACK,
  output logic                  DONE,
  output logic                  DONE_OK,
  output logic                  OVERSIZE,
  output logic [clog2(DEPTH):0] MSG_CNT
);

  localparam int PTR_WIDTH = clog2(DEPTH) + 1;

  ulpb_state_t           state, state_d;
  logic                  abort, abort_d;
  logic                  ok, ok_d;
  logic                  pop;
  logic                  req_d, resp_d, done_d, done_ok_d;
  logic                  first;
  logic [PTR_WIDTH-1:0]  word_cnt;
  logic [PTR_WIDTH-1:0]  msg_start;
  logic [ADDR_WIDTH-1:0] msg_addr;
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic                  full, empty;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_last;
  logic                  accept, last_accept, oversize_hit;
  logic [ADDR_WIDTH-1:0] entry_addr;

  assign accept       = HOST_VALID & ~full;
  assign last_accept  = accept & HOST_LAST;
  assign oversize_hit = accept & ~HOST_LAST & (word_cnt == PTR_WIDTH'(DEPTH - 1));
  assign entry_addr   = first ? HOST_ADDR : msg_addr;

  ulpb_msg_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_WIDTH  (PTR_WIDTH)
  ) u_fifo (
    .clk        (CLK),
    .reset_n    (RESET),
    .push       (accept),
    .push_addr  (entry_addr),
    .push_data  (HOST_DATA),
    .push_last  (HOST_LAST),
    .pop        (pop),
    .rewind     (oversize_hit),
    .rewind_ptr (msg_start),
    .wr_ptr     (wr_ptr),
    .full       (full),
    .empty      (empty),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .head_last  (head_last)
  );

  assign HOST_READY = ~full;
  assign TX_ADDR    = head_addr;
  assign TX_DATA    = head_data;
  assign TX_PEND    = ~empty & ~head_last;

  // An oversize drop also restarts message framing so the next word carries a fresh address.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      first     <= 1'b1;
      word_cnt  <= '0;
      msg_start <= '0;
      msg_addr  <= '0;
      OVERSIZE  <= 1'b0;
    end else begin
      OVERSIZE <= oversize_hit;
      if (accept) begin
        if (first) begin
          msg_addr  <= HOST_ADDR;
          msg_start <= wr_ptr;
        end
        if (HOST_LAST || oversize_hit) begin
          first    <= 1'b1;
          word_cnt <= '0;
        end else begin
          first    <= 1'b0;
          word_cnt <= word_cnt + PTR_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      MSG_CNT <= '0;
    else if (last_accept && state != RACK)
      MSG_CNT <= MSG_CNT + PTR_WIDTH'(1);
    else if (!last_accept && state == RACK)
      MSG_CNT <= MSG_CNT - PTR_WIDTH'(1);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      abort       <= 1'b0;
      ok          <= 1'b0;
      TX_REQ      <= 1'b0;
      TX_RESP_ACK <= 1'b0;
      DONE        <= 1'b0;
      DONE_OK     <= 1'b0;
    end else begin
      state       <= state_d;
      abort       <= abort_d;
      ok          <= ok_d;
      TX_REQ      <= req_d;
      TX_RESP_ACK <= resp_d;
      DONE        <= done_d;
      DONE_OK     <= done_ok_d;
    end
  end

  // TX_REQ is a registered copy of req_d, so it rises one edge after entering REQ and
  // never while the node still holds TX_ACK.
  always_comb begin
    state_d   = state;
    abort_d   = abort;
    ok_d      = ok;
    pop       = 1'b0;
    req_d     = 1'b0;
    resp_d    = 1'b0;
    done_d    = 1'b0;
    done_ok_d = 1'b0;
    case (state)
      IDLE: begin
        abort_d = 1'b0;
        if (MSG_CNT != '0)
          state_d = REQ;
      end
      REQ: begin
        if (TX_FAIL) begin
          abort_d = 1'b1;
          state_d = REL;
        end else if (TX_ACK) begin
          state_d = REL;
        end else begin
          req_d = 1'b1;
        end
      end
      REL: begin
        if (abort || TX_FAIL) begin
          abort_d = 1'b1;
          if (!TX_ACK)
            state_d = FLUSH;
        end else if (!TX_ACK) begin
          pop     = 1'b1;
          state_d = head_last ? WAIT : REQ;
        end
      end
      WAIT: begin
        if (TX_SUCC || TX_FAIL) begin
          ok_d    = TX_SUCC;
          state_d = RACK;
        end
      end
      RACK: begin
        resp_d    = 1'b1;
        done_d    = 1'b1;
        done_ok_d = ok;
        state_d   = IDLE;
      end
      FLUSH: begin
        pop = 1'b1;
        if (head_last) begin
          ok_d    = 1'b0;
          state_d = RACK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_ulpb_tx_queue.sv
// tb_ulpb_tx_queue: directed self-checking bench for ulpb_tx_queue (DEPTH = 4).
`default_nettype none

module tb_ulpb_tx_queue;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic [AW-1:0] HOST_ADDR = '0;
  logic [DW-1:0] HOST_DATA = '0;
  logic          HOST_LAST = 1'b0;
  logic          HOST_VALID = 1'b0;
  logic          HOST_READY;
  logic [AW-1:0] TX_ADDR;
  logic [DW-1:0] TX_DATA;
  logic          TX_PEND;
  logic          TX_REQ;
  logic          TX_ACK = 1'b0;
  logic          TX_SUCC = 1'b0;
  logic          TX_FAIL = 1'b0;
  logic          TX_RESP_ACK;
  logic          DONE;
  logic          DONE_OK;
  logic          OVERSIZE;
  logic [2:0]    MSG_CNT;

  int errors = 0;
  int checks = 0;

  ulpb_tx_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET),
    .HOST_ADDR(HOST_ADDR), .HOST_DATA(HOST_DATA), .HOST_LAST(HOST_LAST),
    .HOST_VALID(HOST_VALID), .HOST_READY(HOST_READY),
    .TX_ADDR(TX_ADDR), .TX_DATA(TX_DATA), .TX_PEND(TX_PEND), .TX_REQ(TX_REQ),
    .TX_ACK(TX_ACK), .TX_SUCC(TX_SUCC), .TX_FAIL(TX_FAIL), .TX_RESP_ACK(TX_RESP_ACK),
    .DONE(DONE), .DONE_OK(DONE_OK), .OVERSIZE(OVERSIZE), .MSG_CNT(MSG_CNT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_req(input logic lvl, input string tag);
    int n;
    n = 0;
    while (TX_REQ !== lvl && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check_eq(tag, TX_REQ, lvl);
  endtask

  // Returns at the negedge after the word was accepted.
  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic l);
    int n;
    HOST_ADDR  = a;
    HOST_DATA  = d;
    HOST_LAST  = l;
    HOST_VALID = 1'b1;
    n = 0;
    while (!HOST_READY && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check_eq("push_ready", HOST_READY, 1'b1);
    @(negedge CLK);
    HOST_VALID = 1'b0;
    HOST_LAST  = 1'b0;
  endtask

  task automatic node_word(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic pend,
                           input string tag);
    wait_req(1'b1, {tag, "_req"});
    check_eq({tag, "_addr"}, TX_ADDR, a);
    check_eq({tag, "_data"}, TX_DATA, d);
    check_eq({tag, "_pend"}, TX_PEND, pend);
    TX_ACK = 1'b1;
    wait_req(1'b0, {tag, "_rel"});
    TX_ACK = 1'b0;
    @(negedge CLK);
  endtask

  task automatic node_result(input logic succ, input string tag);
    int n;
    TX_SUCC = succ;
    TX_FAIL = ~succ;
    n = 0;
    while (!TX_RESP_ACK && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check_eq({tag, "_rack"}, TX_RESP_ACK, 1'b1);
    check_eq({tag, "_done"}, DONE, 1'b1);
    check_eq({tag, "_done_ok"}, DONE_OK, succ);
    TX_SUCC = 1'b0;
    TX_FAIL = 1'b0;
    @(negedge CLK);
    check_eq({tag, "_rack_pulse"}, TX_RESP_ACK, 1'b0);
    check_eq({tag, "_done_pulse"}, DONE, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    check_eq("rst_ready", HOST_READY, 1'b1);
    check_eq("rst_req", TX_REQ, 1'b0);
    check_eq("rst_rack", TX_RESP_ACK, 1'b0);
    check_eq("rst_done", DONE, 1'b0);
    check_eq("rst_oversize", OVERSIZE, 1'b0);
    check_eq("rst_msg_cnt", MSG_CNT, 3'd0);
    check_eq("rst_pend", TX_PEND, 1'b0);
    check_eq("rst_addr", TX_ADDR, 8'h00);
    check_eq("rst_data", TX_DATA, 32'h0);
    RESET = 1'b1;
    @(negedge CLK);

    // Single-word message and start latency
    push(8'hA5, 32'h1234_5678, 1'b1);
    check_eq("w1_cnt", MSG_CNT, 3'd1);
    check_eq("w1_lat0", TX_REQ, 1'b0);
    @(negedge CLK);
    check_eq("w1_lat1", TX_REQ, 1'b0);
    @(negedge CLK);
    check_eq("w1_lat2", TX_REQ, 1'b1);
    node_word(8'hA5, 32'h1234_5678, 1'b0, "w1");
    node_result(1'b1, "w1");
    check_eq("w1_cnt_end", MSG_CNT, 3'd0);

    // Three-word message; later words carry a different HOST_ADDR that must be ignored
    push(8'h10, 32'h1, 1'b0);
    push(8'hEE, 32'h2, 1'b0);
    push(8'hEE, 32'h3, 1'b1);
    node_word(8'h10, 32'h1, 1'b1, "w3a");
    node_word(8'h10, 32'h2, 1'b1, "w3b");
    node_word(8'h10, 32'h3, 1'b0, "w3c");
    node_result(1'b1, "w3");

    // TX_FAIL during word 2: remainder flushed, next message intact
    push(8'h20, 32'hA, 1'b0);
    push(8'h21, 32'hB, 1'b0);
    push(8'h22, 32'hC, 1'b1);
    push(8'h30, 32'hD, 1'b1);
    check_eq("f_cnt", MSG_CNT, 3'd2);
    node_word(8'h20, 32'hA, 1'b1, "fa");
    wait_req(1'b1, "fb_req");
    check_eq("fb_data", TX_DATA, 32'hB);
    TX_FAIL = 1'b1;
    @(negedge CLK);
    check_eq("f_req_drop", TX_REQ, 1'b0);
    node_result(1'b0, "f");
    check_eq("f_cnt_after", MSG_CNT, 3'd1);
    node_word(8'h30, 32'hD, 1'b0, "fd");
    node_result(1'b1, "fd");

    // Oversize: DEPTH words without LAST
    push(8'h40, 32'h11, 1'b0);
    push(8'h41, 32'h12, 1'b0);
    push(8'h42, 32'h13, 1'b0);
    push(8'h43, 32'h14, 1'b0);
    check_eq("ov_pulse", OVERSIZE, 1'b1);
    check_eq("ov_cnt", MSG_CNT, 3'd0);
    check_eq("ov_ready", HOST_READY, 1'b1);
    check_eq("ov_pend", TX_PEND, 1'b0);
    @(negedge CLK);
    check_eq("ov_pulse_end", OVERSIZE, 1'b0);
    repeat (5) @(negedge CLK);
    check_eq("ov_no_req", TX_REQ, 1'b0);
    push(8'h44, 32'h55, 1'b1);
    node_word(8'h44, 32'h55, 1'b0, "ovn");
    node_result(1'b1, "ovn");

    // Full queue: two two-word messages fill DEPTH = 4
    push(8'h50, 32'h100, 1'b0);
    push(8'h51, 32'h101, 1'b1);
    push(8'h60, 32'h200, 1'b0);
    push(8'h61, 32'h201, 1'b1);
    check_eq("full_ready", HOST_READY, 1'b0);
    check_eq("full_cnt", MSG_CNT, 3'd2);
    HOST_ADDR  = 8'h70;
    HOST_DATA  = 32'h300;
    HOST_LAST  = 1'b1;
    HOST_VALID = 1'b1;
    wait_req(1'b1, "fp_req");
    check_eq("fp_addr", TX_ADDR, 8'h50);
    check_eq("fp_data", TX_DATA, 32'h100);
    TX_ACK = 1'b1;
    wait_req(1'b0, "fp_rel");
    check_eq("full_ready_hold", HOST_READY, 1'b0);
    TX_ACK = 1'b0;
    @(negedge CLK);
    check_eq("full_ready_rise", HOST_READY, 1'b1);
    @(negedge CLK);
    HOST_VALID = 1'b0;
    HOST_LAST  = 1'b0;
    check_eq("full_refill", HOST_READY, 1'b0);
    check_eq("full_cnt3", MSG_CNT, 3'd3);
    node_word(8'h50, 32'h101, 1'b0, "fp2");
    node_result(1'b1, "fp");
    node_word(8'h60, 32'h200, 1'b1, "fq1");
    node_word(8'h60, 32'h201, 1'b0, "fq2");
    node_result(1'b1, "fq");
    node_word(8'h70, 32'h300, 1'b0, "fr");
    node_result(1'b1, "fr");
    check_eq("full_cnt_end", MSG_CNT, 3'd0);

    // Asynchronous reset while in REL
    push(8'h77, 32'hCAFE, 1'b1);
    push(8'h78, 32'hF00D, 1'b1);
    wait_req(1'b1, "ar_req");
    TX_ACK = 1'b1;
    wait_req(1'b0, "ar_rel");
    RESET = 1'b0;
    #1;
    check_eq("ar_req0", TX_REQ, 1'b0);
    check_eq("ar_rack", TX_RESP_ACK, 1'b0);
    check_eq("ar_done", DONE, 1'b0);
    check_eq("ar_done_ok", DONE_OK, 1'b0);
    check_eq("ar_oversize", OVERSIZE, 1'b0);
    check_eq("ar_cnt", MSG_CNT, 3'd0);
    check_eq("ar_ready", HOST_READY, 1'b1);
    check_eq("ar_addr", TX_ADDR, 8'h00);
    check_eq("ar_data", TX_DATA, 32'h0);
    check_eq("ar_pend", TX_PEND, 1'b0);
    TX_ACK = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    check_eq("ar_idle", TX_REQ, 1'b0);
    check_eq("ar_done_none", DONE, 1'b0);
    push(8'h88, 32'hBEEF, 1'b1);
    node_word(8'h88, 32'hBEEF, 1'b0, "arn");
    node_result(1'b1, "arn");
    check_eq("arn_cnt", MSG_CNT, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ulpb_tx_queue.md
# ulpb_tx_queue

Transmit-side message queue sitting directly upstream of the ULPB bus node's TX interface. The host writes complete messages into it, each being one address plus 1..DEPTH data words. The queue holds each message until it is complete, then drives the node's four-phase TX_REQ/TX_ACK handshake word by word with TX_PEND. It collects the node's TX_SUCC/TX_FAIL result, acknowledges it, and reports per-message status to the host.

## Interface
Parameters:
- ADDR_WIDTH, 8, bus address width
- DATA_WIDTH, 32, data word width
- DEPTH, 4, FIFO entries (power of two, ≥2); maximum words per message

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous, active-low reset
- HOST_ADDR  in  ADDR_WIDTH  destination address; sampled with the first word of a message
- HOST_DATA  in  DATA_WIDTH  data word
- HOST_LAST  in  1  marks the last word of a message
- HOST_VALID  in  1  write strobe
- HOST_READY  out  1  queue can accept a word
- TX_ADDR  out  ADDR_WIDTH  to node
- TX_DATA  out  DATA_WIDTH  to node
- TX_PEND  out  1  to node; more words follow the current one
- TX_REQ  out  1  to node
- TX_ACK  in  1  from node
- TX_SUCC  in  1  from node
- TX_FAIL  in  1  from node
- TX_RESP_ACK  out  1  to node
- DONE  out  1  one-cycle pulse when a message finishes
- DONE_OK  out  1  valid with DONE: 1 = success, 0 = fail or oversize
- OVERSIZE  out  1  one-cycle pulse when an oversize message is dropped
- MSG_CNT  out  log2(DEPTH)+1  complete messages queued

## Operation
- Storage: DEPTH entries {addr, data, last}. Write and read pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH. Full when the pointers differ only in the MSB.
- Host write: accepted when HOST_VALID & HOST_READY. HOST_READY = ~full.
- First-word tracking: an internal first flag is set after reset and after every accepted LAST word. Entry addr = HOST_ADDR on a first word, otherwise the addr latched at the message start.
- Completion: an accepted LAST increments msg_cnt.
- Oversize: the DEPTH-th consecutive word of one message without LAST is accepted, then OVERSIZE pulses. The whole partial message is discarded by restoring wr_ptr to its message-start value. msg_cnt is unchanged.
- Outputs to the node are driven from the head entry: TX_ADDR = head.addr, TX_DATA = head.data, TX_PEND = ~head.last.
- FSM states:
  - IDLE: go to REQ when msg_cnt ≠ 0.
  - REQ: TX_REQ = 1. On TX_ACK, go to REL.
  - REL: TX_REQ = 0. On ~TX_ACK, pop the head. If the popped word had last = 1, go to WAIT; otherwise go to REQ.
  - WAIT: on TX_SUCC or TX_FAIL, latch ok = TX_SUCC and go to RACK.
  - RACK: TX_RESP_ACK = 1 for exactly one cycle. DONE pulses with DONE_OK = ok, msg_cnt decrements, go to IDLE.
- TX_FAIL seen in REQ or REL (receiver reset mid-message):
  - Drop TX_REQ.
  - Wait for ~TX_ACK.
  - Enter FLUSH, which pops one entry per cycle up to and including the last = 1 entry.
  - Then go to RACK with ok = 0.
- Simultaneous host write and pop are legal in any state. A pop never reads an uncommitted entry, because transmission starts only on msg_cnt ≠ 0.
- msg_cnt with simultaneous +1 (LAST accepted) and −1 (RACK): net unchanged.

## Timing
- Reset values:
  - HOST_READY = 1
  - TX_REQ, TX_RESP_ACK, DONE, DONE_OK, OVERSIZE, MSG_CNT = 0
  - TX_PEND = 0, TX_ADDR = 0, TX_DATA = 0 (storage cleared)
  - pointers = 0, state = IDLE, first flag = 1
- All outputs are registered, except TX_ADDR/TX_DATA/TX_PEND, which are combinational from the head entry.
- Start latency: TX_REQ rises on the second CLK edge after the LAST word is accepted.
- Between words: TX_REQ re-asserts on the edge after TX_ACK is seen low. A complete message is always buffered, so the node never underflows.
- TX_REQ is never reasserted while TX_ACK = 1.
- Reset mid-operation: everything returns to its reset value. Queued messages are lost and no DONE is issued.

## Structure
- Shared package ulpb_pkg: the FSM state encodings IDLE/REQ/REL/WAIT/RACK/FLUSH and the log2 helper used by the other ULPB blocks.
- One natural sub-module, ulpb_msg_fifo: the storage plus pointers and full/empty logic. It provides push, pop and wr_ptr rewind.
- The control FSM and msg_cnt live in the top module.

## Test plan
- Single-word message: push addr 0xA5, data 0x12345678, LAST. Expect TX_REQ with TX_PEND = 0 and TX_DATA = 0x12345678. After ACK and TX_SUCC, expect one TX_RESP_ACK pulse, then DONE with DONE_OK = 1 and MSG_CNT back to 0.
- Three-word message: push words 0x1, 0x2, 0x3 (LAST on 0x3) to addr 0x10. Expect three REQ/ACK cycles with TX_PEND = 1, 1, 0, then success.
- TX_FAIL after word 1 of a three-word message: expect the two remaining words flushed, DONE with DONE_OK = 0, then the next queued message transmits with addr intact.
- Oversize: push DEPTH = 4 words without LAST. Expect an OVERSIZE pulse, no TX_REQ, MSG_CNT = 0, and the queue empty with HOST_READY = 1.
- Full queue: with two two-word messages queued (DEPTH = 4), expect HOST_READY = 0. A pop frees an entry and HOST_READY rises the next cycle; a simultaneous push in that cycle is accepted.
- Async RESET asserted in REL state: expect all outputs at their reset values immediately, and a subsequent message transmitted normally.
